// File: rtl/ps2kb_xlat_fifo_if.sv
// Keyboard-port bundle: raw set-2 byte input side plus the host irq/keycode handshake.
interface ps2kb_xlat_fifo_if #(
  parameter int DEPTH = 16
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic          in_valid;
  logic [7:0]    in_code;
  logic          xlat_en;
  logic          reset_keybord;
  logic          clear_keycode;
  logic          irq;
  logic [7:0]    keycode;
  logic [LW-1:0] fifo_level;
  logic          overflow;

  modport master (
    output in_valid, in_code, xlat_en, reset_keybord, clear_keycode,
    input  irq, keycode, fifo_level, overflow
  );

  modport slave (
    input  in_valid, in_code, xlat_en, reset_keybord, clear_keycode,
    output irq, keycode, fifo_level, overflow
  );
endinterface

// File: rtl/ps2kb_xlat_fifo.sv
// Set-2 to set-1 scancode translator feeding a receive FIFO, drained one byte at a time
// through the XT keyboard port irq/keycode/clear_keycode handshake.
module ps2kb_xlat_fifo #(
  parameter int DEPTH   = 16,
  parameter int IRQ_GAP = 2
) (
  input logic              clock,
  input logic              reset,
  ps2kb_xlat_fifo_if.slave bus
);
  localparam int LW = $clog2(DEPTH) + 1;
  localparam int AW = $clog2(DEPTH);
  localparam int GW = $clog2(IRQ_GAP + 1);

  // Standard set-2 to set-1 translation map, indexed by the 7-bit set-2 code.
  localparam logic [0:127][7:0] XLAT = {
    8'hff, 8'h43, 8'h41, 8'h3f, 8'h3d, 8'h3b, 8'h3c, 8'h58, 8'h64, 8'h44, 8'h42, 8'h40, 8'h3e, 8'h0f, 8'h29, 8'h59,
    8'h65, 8'h38, 8'h2a, 8'h70, 8'h1d, 8'h10, 8'h02, 8'h5a, 8'h66, 8'h71, 8'h2c, 8'h1f, 8'h1e, 8'h11, 8'h03, 8'h5b,
    8'h67, 8'h2e, 8'h2d, 8'h20, 8'h12, 8'h05, 8'h04, 8'h5c, 8'h68, 8'h39, 8'h2f, 8'h21, 8'h14, 8'h13, 8'h06, 8'h5d,
    8'h69, 8'h31, 8'h30, 8'h23, 8'h22, 8'h15, 8'h07, 8'h5e, 8'h6a, 8'h72, 8'h32, 8'h24, 8'h16, 8'h08, 8'h09, 8'h5f,
    8'h6b, 8'h33, 8'h25, 8'h17, 8'h18, 8'h0b, 8'h0a, 8'h60, 8'h6c, 8'h34, 8'h35, 8'h26, 8'h27, 8'h19, 8'h0c, 8'h61,
    8'h6d, 8'h73, 8'h28, 8'h74, 8'h1a, 8'h0d, 8'h62, 8'h6e, 8'h3a, 8'h36, 8'h1c, 8'h1b, 8'h75, 8'h2b, 8'h63, 8'h76,
    8'h55, 8'h56, 8'h77, 8'h78, 8'h79, 8'h7a, 8'h0e, 8'h7b, 8'h7c, 8'h4f, 8'h7d, 8'h4b, 8'h47, 8'h7e, 8'h7f, 8'h6f,
    8'h52, 8'h53, 8'h50, 8'h4c, 8'h4d, 8'h48, 8'h01, 8'h45, 8'h57, 8'h4e, 8'h51, 8'h4a, 8'h37, 8'h49, 8'h46, 8'h54
  };

  // 0x83 (F7) is the one set-2 make code above 0x7F that still has a set-1 equivalent.
  function automatic logic [7:0] set2_to_set1(input logic [7:0] c);
    if (c == 8'h83) return 8'h41;
    return XLAT[c[6:0]];
  endfunction

  logic          r_break_flag;
  logic          r_dec_vld_p0;
  logic [7:0]    r_dec_byte_p0;
  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [LW-1:0] r_count;
  logic          r_overflow;
  logic          r_irq;
  logic [7:0]    r_keycode;
  logic [GW-1:0] r_gap;

  logic       w_dec_vld;
  logic [7:0] w_dec_byte;
  logic       w_break_nxt;
  logic       w_full;
  logic       w_push;
  logic       w_pop;

  always_comb begin
    w_dec_vld   = bus.in_valid;
    w_dec_byte  = bus.in_code;
    w_break_nxt = r_break_flag;
    if (!bus.xlat_en) begin
      w_break_nxt = 1'b0;
    end else if (bus.in_valid) begin
      if (bus.in_code == 8'hF0) begin
        w_dec_vld   = 1'b0;
        w_break_nxt = 1'b1;
      end else if (bus.in_code == 8'hE0 || bus.in_code == 8'hE1) begin
        w_break_nxt = r_break_flag;
      end else if (!bus.in_code[7] || bus.in_code == 8'h83) begin
        w_dec_byte  = set2_to_set1(bus.in_code) | {r_break_flag, 7'b0};
        w_break_nxt = 1'b0;
      end else begin
        w_break_nxt = 1'b0;
      end
    end
  end

  // Stage p0: decoded byte waiting for its FIFO write.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_dec_vld_p0 <= 1'b0;
      r_break_flag <= 1'b0;
    end else if (bus.reset_keybord) begin
      r_dec_vld_p0 <= 1'b0;
      r_break_flag <= 1'b0;
    end else begin
      r_dec_vld_p0 <= w_dec_vld;
      r_break_flag <= w_break_nxt;
    end
  end

  always_ff @(posedge clock) begin
    r_dec_byte_p0 <= w_dec_byte;
  end

  // Pop looks at the level before this cycle's write, so a byte landing in an empty
  // FIFO is presented one cycle later rather than bypassing the queue.
  assign w_full = (r_count == LW'(DEPTH));
  assign w_push = r_dec_vld_p0 && !w_full;
  assign w_pop  = !r_irq && (r_gap == '0) && (r_count != '0);

  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_wr_ptr] <= r_dec_byte_p0;
  end

  // FIFO pointers and the host-facing presented byte.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      r_irq      <= 1'b0;
      r_keycode  <= 8'h00;
      r_gap      <= '0;
    end else if (bus.reset_keybord) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      r_irq      <= 1'b1;
      r_keycode  <= 8'hAA;
      r_gap      <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (r_dec_vld_p0 && w_full) r_overflow <= 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (bus.clear_keycode && r_irq) begin
        r_irq     <= 1'b0;
        r_keycode <= 8'h00;
        r_gap     <= GW'(IRQ_GAP);
      end else begin
        if (w_pop) begin
          r_irq     <= 1'b1;
          r_keycode <= r_mem[r_rd_ptr];
        end
        if (r_gap != '0) r_gap <= r_gap - 1'b1;
      end
    end
  end

  assign bus.irq        = r_irq;
  assign bus.keycode    = r_keycode;
  assign bus.fifo_level = r_count;
  assign bus.overflow   = r_overflow;

endmodule

// File: tb/tb_ps2kb_xlat_fifo.sv
// Bench for ps2kb_xlat_fifo: fixed vectors, handshake/overflow/reset sequences and
// randomized bursts scored against a queue-based reference of the translation rules.
module tb_ps2kb_xlat_fifo;
  localparam int DEPTH   = 16;
  localparam int IRQ_GAP = 2;
  localparam int NV      = 7;
  localparam int NP      = 24;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  ps2kb_xlat_fifo_if #(.DEPTH(DEPTH)) bus ();

  ps2kb_xlat_fifo #(.DEPTH(DEPTH), .IRQ_GAP(IRQ_GAP)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic       xlat;
    int         n;
    logic [7:0] in_b [6];
    int         m;
    logic [7:0] out_b [6];
  } vec_t;

  typedef struct {
    logic [7:0] s2;
    logic [7:0] s1;
  } pair_t;

  vec_t       vecs [NV];
  pair_t      pairs [NP];
  logic [7:0] mq [$];
  logic       m_brk;
  int         n_checks = 0;
  int         n_fail   = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h, required %0h", nm, act, exp);
    end
  endtask

  task automatic send_byte(input logic x, input logic [7:0] c);
    bus.xlat_en  = x;
    bus.in_valid = 1'b1;
    bus.in_code  = c;
    @(negedge clock);
    bus.in_valid = 1'b0;
  endtask

  task automatic pulse_clear();
    bus.clear_keycode = 1'b1;
    @(negedge clock);
    bus.clear_keycode = 1'b0;
  endtask

  task automatic expect_byte(input string nm, input logic [7:0] exp);
    int w;
    w = 0;
    while (bus.irq !== 1'b1 && w < 40) begin
      @(negedge clock);
      w++;
    end
    check({nm, "_irq"}, 32'(bus.irq), 32'd1);
    check(nm, 32'(bus.keycode), 32'(exp));
    pulse_clear();
  endtask

  function automatic logic [7:0] ref_map(input logic [7:0] c);
    foreach (pairs[i]) if (pairs[i].s2 == c) return pairs[i].s1;
    return 8'hFF;
  endfunction

  // Reference: applies the translation rules byte by byte to an expected-output queue.
  function automatic void model_feed(input logic x, input logic [7:0] c);
    if (!x) begin
      m_brk = 1'b0;
      mq.push_back(c);
    end else if (c == 8'hF0) begin
      m_brk = 1'b1;
    end else if (c == 8'hE0 || c == 8'hE1) begin
      mq.push_back(c);
    end else if (c < 8'h80 || c == 8'h83) begin
      mq.push_back(ref_map(c) | (m_brk ? 8'h80 : 8'h00));
      m_brk = 1'b0;
    end else begin
      mq.push_back(c);
      m_brk = 1'b0;
    end
  endfunction

  function automatic logic [7:0] pick_code();
    int r;
    r = $urandom_range(0, NP + 3);
    if (r < NP) return pairs[r].s2;
    if (r == NP) return 8'hF0;
    if (r == NP + 1) return 8'hE0;
    if (r == NP + 2) return 8'hE1;
    return 8'($urandom_range(8'h84, 8'hDF));
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int low;
    int target;
    int fed;
    logic x;
    logic [7:0] c;

    vecs[0] = '{1'b1, 3, '{8'h1C, 8'hF0, 8'h1C, 8'h00, 8'h00, 8'h00}, 2, '{8'h1E, 8'h9E, 8'h00, 8'h00, 8'h00, 8'h00}};
    vecs[1] = '{1'b1, 5, '{8'hE0, 8'h75, 8'hE0, 8'hF0, 8'h75, 8'h00}, 4, '{8'hE0, 8'h48, 8'hE0, 8'hC8, 8'h00, 8'h00}};
    vecs[2] = '{1'b0, 3, '{8'h1C, 8'hF0, 8'h1C, 8'h00, 8'h00, 8'h00}, 3, '{8'h1C, 8'hF0, 8'h1C, 8'h00, 8'h00, 8'h00}};
    vecs[3] = '{1'b1, 3, '{8'h76, 8'hF0, 8'h76, 8'h00, 8'h00, 8'h00}, 2, '{8'h01, 8'h81, 8'h00, 8'h00, 8'h00, 8'h00}};
    vecs[4] = '{1'b1, 6, '{8'h5A, 8'h12, 8'h11, 8'h83, 8'hF0, 8'h83}, 5, '{8'h1C, 8'h2A, 8'h38, 8'h41, 8'hC1, 8'h00}};
    vecs[5] = '{1'b1, 3, '{8'hF0, 8'hAB, 8'h1C, 8'h00, 8'h00, 8'h00}, 2, '{8'hAB, 8'h1E, 8'h00, 8'h00, 8'h00, 8'h00}};
    vecs[6] = '{1'b1, 3, '{8'hE1, 8'h14, 8'h77, 8'h00, 8'h00, 8'h00}, 3, '{8'hE1, 8'h1D, 8'h45, 8'h00, 8'h00, 8'h00}};

    pairs = '{'{8'h1C, 8'h1E}, '{8'h32, 8'h30}, '{8'h21, 8'h2E}, '{8'h23, 8'h20}, '{8'h24, 8'h12},
              '{8'h2B, 8'h21}, '{8'h34, 8'h22}, '{8'h33, 8'h23}, '{8'h43, 8'h17}, '{8'h3B, 8'h24},
              '{8'h42, 8'h25}, '{8'h4B, 8'h26}, '{8'h16, 8'h02}, '{8'h1E, 8'h03}, '{8'h29, 8'h39},
              '{8'h5A, 8'h1C}, '{8'h66, 8'h0E}, '{8'h0D, 8'h0F}, '{8'h76, 8'h01}, '{8'h12, 8'h2A},
              '{8'h11, 8'h38}, '{8'h75, 8'h48}, '{8'h83, 8'h41}, '{8'h05, 8'h3B}};

    bus.in_valid      = 1'b0;
    bus.in_code       = 8'h00;
    bus.xlat_en       = 1'b1;
    bus.reset_keybord = 1'b0;
    bus.clear_keycode = 1'b0;
    m_brk             = 1'b0;

    repeat (3) @(negedge clock);
    check("rst_irq", 32'(bus.irq), 32'd0);
    check("rst_keycode", 32'(bus.keycode), 32'd0);
    check("rst_level", 32'(bus.fifo_level), 32'd0);
    check("rst_overflow", 32'(bus.overflow), 32'd0);
    reset = 1'b0;
    @(negedge clock);

    // Latency: decode, write, pop -> irq on the third edge.
    send_byte(1'b1, 8'h1C);
    check("lat_edge1_irq", 32'(bus.irq), 32'd0);
    @(negedge clock);
    check("lat_edge2_irq", 32'(bus.irq), 32'd0);
    check("lat_edge2_level", 32'(bus.fifo_level), 32'd1);
    @(negedge clock);
    check("lat_edge3_irq", 32'(bus.irq), 32'd1);
    check("lat_edge3_key", 32'(bus.keycode), 32'h1E);
    check("lat_edge3_level", 32'(bus.fifo_level), 32'd0);

    // Minimum irq-low gap between consecutive bytes.
    send_byte(1'b1, 8'h2B);
    repeat (3) @(negedge clock);
    check("gap_level_held", 32'(bus.fifo_level), 32'd1);
    check("gap_key_held", 32'(bus.keycode), 32'h1E);
    pulse_clear();
    check("clr_irq", 32'(bus.irq), 32'd0);
    check("clr_key", 32'(bus.keycode), 32'd0);
    low = 0;
    while (bus.irq !== 1'b1 && low < 40) begin
      low++;
      @(negedge clock);
    end
    check("gap_min_low", 32'(low >= IRQ_GAP), 32'd1);
    expect_byte("gap_second", 8'h21);

    for (int v = 0; v < NV; v++) begin
      for (int j = 0; j < vecs[v].n; j++) send_byte(vecs[v].xlat, vecs[v].in_b[j]);
      for (int j = 0; j < vecs[v].m; j++) expect_byte($sformatf("vec%0d_b%0d", v, j), vecs[v].out_b[j]);
      repeat (8) @(negedge clock);
      check($sformatf("vec%0d_no_extra", v), 32'(bus.irq), 32'd0);
      check($sformatf("vec%0d_level", v), 32'(bus.fifo_level), 32'd0);
    end

    // Overflow: DEPTH+2 makes with no acknowledge.
    for (int i = 0; i < DEPTH + 2; i++) send_byte(1'b1, 8'h16);
    repeat (4) @(negedge clock);
    check("ovf_irq", 32'(bus.irq), 32'd1);
    check("ovf_key", 32'(bus.keycode), 32'h02);
    check("ovf_level", 32'(bus.fifo_level), 32'(DEPTH));
    check("ovf_flag", 32'(bus.overflow), 32'd1);
    for (int i = 0; i < DEPTH + 1; i++) expect_byte($sformatf("ovf_drain%0d", i), 8'h02);
    repeat (8) @(negedge clock);
    check("ovf_exactly_one_drop", 32'(bus.irq), 32'd0);
    check("ovf_sticky", 32'(bus.overflow), 32'd1);

    // reset_keybord with five queued bytes and a pending break prefix.
    for (int i = 0; i < 6; i++) send_byte(1'b1, 8'h1C);
    send_byte(1'b1, 8'hF0);
    repeat (4) @(negedge clock);
    check("kbrst_pre_level", 32'(bus.fifo_level), 32'd5);
    bus.reset_keybord = 1'b1;
    @(negedge clock);
    bus.reset_keybord = 1'b0;
    check("kbrst_key", 32'(bus.keycode), 32'hAA);
    check("kbrst_irq", 32'(bus.irq), 32'd1);
    check("kbrst_level", 32'(bus.fifo_level), 32'd0);
    check("kbrst_overflow", 32'(bus.overflow), 32'd0);
    expect_byte("kbrst_bat", 8'hAA);
    send_byte(1'b1, 8'h1C);
    expect_byte("kbrst_break_cleared", 8'h1E);
    repeat (8) @(negedge clock);
    check("kbrst_no_stale", 32'(bus.irq), 32'd0);

    // Asynchronous reset in the middle of an overflowing burst.
    for (int i = 0; i < DEPTH + 3; i++) send_byte(1'b1, 8'h1C);
    repeat (3) @(negedge clock);
    check("areset_pre_irq", 32'(bus.irq), 32'd1);
    check("areset_pre_ovf", 32'(bus.overflow), 32'd1);
    bus.in_valid = 1'b1;
    bus.in_code  = 8'h1C;
    #2 reset = 1'b1;
    #1;
    check("areset_irq", 32'(bus.irq), 32'd0);
    check("areset_key", 32'(bus.keycode), 32'd0);
    check("areset_level", 32'(bus.fifo_level), 32'd0);
    check("areset_ovf", 32'(bus.overflow), 32'd0);
    bus.in_valid = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    repeat (8) @(negedge clock);
    check("areset_post_irq", 32'(bus.irq), 32'd0);
    check("areset_post_level", 32'(bus.fifo_level), 32'd0);
    send_byte(1'b1, 8'h1C);
    expect_byte("areset_first", 8'h1E);

    // Randomized bursts against the reference queue.
    m_brk = 1'b0;
    for (int b = 0; b < 8; b++) begin
      mq.delete();
      target = $urandom_range(1, DEPTH);
      fed = 0;
      while (mq.size() < target && fed < 3 * DEPTH) begin
        x = ($urandom_range(0, 3) != 0);
        c = pick_code();
        model_feed(x, c);
        send_byte(x, c);
        repeat ($urandom_range(0, 2)) @(negedge clock);
        fed++;
      end
      for (int j = 0; mq.size() > 0; j++) expect_byte($sformatf("rnd%0d_b%0d", b, j), mq.pop_front());
      repeat (8) @(negedge clock);
      check($sformatf("rnd%0d_no_extra", b), 32'(bus.irq), 32'd0);
      check($sformatf("rnd%0d_level", b), 32'(bus.fifo_level), 32'd0);
      check($sformatf("rnd%0d_ovf", b), 32'(bus.overflow), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/ps2kb_xlat_fifo.md
Name: ps2kb_xlat_fifo

Overview:
Parametrised set-2 to set-1 keyboard scancode translator with a receive FIFO, for the XT core's keyboard port. It accepts a raw set-2 byte stream with F0 break and E0/E1 prefixes, and translates each make/break into set-1 bytes. Results are queued and presented one at a time to the host through an irq/keycode/clear_keycode handshake, so bursts are not lost while the host services the interrupt.

Parameters:
DEPTH, 16, FIFO entries; power of two, minimum 2.
IRQ_GAP, 2, minimum clock cycles irq stays low between consecutive bytes; minimum 1.
LW, $clog2(DEPTH)+1, width of fifo_level (localparam, derived).

Ports:
clock  in  1  system clock
reset  in  1  async active-high reset
in_valid  in  1  one-cycle strobe: in_code carries a new set-2 byte
in_code  in  8  raw set-2 byte
xlat_en  in  1  1 = translate to set 1; 0 = raw pass-through, nothing swallowed
reset_keybord  in  1  one-cycle request: flush and emit BAT code 0xAA
clear_keycode  in  1  one-cycle host acknowledge of the presented byte
irq  out  1  presented byte valid
keycode  out  8  presented byte; stable while irq=1
fifo_level  out  LW  entries queued, excluding the presented byte
overflow  out  1  sticky: a byte was dropped because the FIFO was full

Behaviour:
- Reset: clock is clock; reset is reset, asynchronous, active-high. At reset: irq=0, keycode=0x00, fifo_level=0, overflow=0, break_flag=0, gap counter=0.
- Input decode stage (registered, 1 cycle). Applies only when in_valid=1 and xlat_en=1:
  - 0xF0: set break_flag; nothing is enqueued.
  - 0xE0 / 0xE1: enqueued unchanged; break_flag is not changed.
  - 0x00..0x7F: enqueue table(code) | (break_flag ? 0x80 : 0x00), then clear break_flag. Table is the standard set-2 to set-1 map, e.g. 1C->1E, 76->01, 5A->1C, 12->2A, 11->38, 83->41 (special case).
  - Other 0x80..0xFF: enqueued unchanged; break_flag is cleared.
- xlat_en=0: every in_valid byte is enqueued as-is, and break_flag is held at 0.
- Enqueue happens the cycle after in_valid.
- FIFO full at enqueue: the byte is dropped and overflow is set. Pending break_flag is still consumed.
- Output stage:
  - A pop occurs when irq=0, the gap counter=0 and the FIFO is non-empty.
  - On pop: keycode <= head, irq <= 1 on the next edge.
  - Best-case latency from in_valid to irq=1 is 3 cycles (decode, write, pop).
- clear_keycode while irq=1: irq <= 0, keycode <= 0x00, gap counter <= IRQ_GAP.
  - The counter decrements each cycle down to 0.
  - The next pop is allowed only when the counter is 0, so irq is low for at least IRQ_GAP cycles.
  - clear_keycode while irq=0 is ignored.
- Simultaneous enqueue and pop in the same cycle: both take effect; fifo_level is unchanged. A byte written while the FIFO is empty is not popped in the same cycle.
- reset_keybord has highest priority over clear_keycode, in_valid and pop. In one cycle it:
  - flushes the FIFO (level 0);
  - clears break_flag, overflow and the gap counter;
  - sets keycode <= 0xAA, irq <= 1.
  - A byte in the decode stage in that same cycle is discarded.
- fifo_level reports 0..DEPTH; pointers wrap modulo DEPTH.

Test Plan:
- xlat_en=1; in_code sequence 1C, F0, 1C -> two irq cycles presenting 0x1E then 0x9E. Each is cleared by clear_keycode, and irq is low for at least IRQ_GAP cycles between them.
- Extended key: E0, 75, E0, F0, 75 -> bytes presented in order E0, 48, E0, C8; fifo_level returns to 0.
- xlat_en=0: 1C, F0, 1C -> 1C, F0, 1C presented unchanged; no 0x80 bits added.
- With no clear_keycode, send DEPTH+2 makes of 0x16 -> first byte (0x02) presented, fifo_level=DEPTH, overflow=1, exactly one byte dropped. Then clear repeatedly -> DEPTH+1 bytes of 0x02 delivered.
- reset_keybord with 5 bytes queued and break_flag set -> next cycle keycode=0xAA, irq=1, fifo_level=0, overflow=0. A subsequent 1C yields 0x1E, not 0x9E.
- Assert reset asynchronously mid-burst -> all outputs zero immediately. After release, no stale bytes and no irq until new input.
